// File: rtl/keypad_pkg.sv
// keypad_pkg: FSM states, key map and row priority shared by the keypad encoder.
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} kp_state_t;
  // Nibble {row, col} holds the legend printed on that key.
  localparam logic [15:0][3:0] KEYMAP = 64'hDF0E_C987_B654_A321;
  function automatic logic [1:0] rowEnc(input logic [3:0] rows);
    return !rows[0] ? 2'd0 : !rows[1] ? 2'd1 : !rows[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for asynchronous board inputs.
module sync2 #(
  parameter int W = 4,
  parameter logic [W-1:0] INIT = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      meta <= INIT;
      q <= INIT;
    end else begin
      meta <= d;
      q <= meta;
    end
endmodule

// File: rtl/keypad_encoder.sv
// keypad_encoder: scans a 4x4 active-low keypad, debounces presses and
// delivers hex codes on valid/ready while shifting them into a digit register.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE_CNT = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_i,
  output logic [3:0]  col_o,
  output logic [3:0]  code_data,
  output logic        code_valid,
  input  logic        code_ready,
  output logic [15:0] digits,
  output logic        overflow
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CNT - 1);

  kp_state_t     state;
  logic [3:0]    rowS, latRow, code;
  logic [SW-1:0] scanCnt;
  logic [DW-1:0] dbCnt;
  logic [1:0]    colIdx;
  logic          allHigh, emit, accept, xfer;

  sync2 #(.W(4), .INIT(4'hF)) uSync (.clk(clk), .rst_n(rst_n), .d(row_i), .q(rowS));

  assign col_o = ~(4'b0001 << colIdx);
  assign allHigh = rowS == 4'hF;
  assign emit = state == PRESS_DB && rowS == latRow && dbCnt == DB_LAST;
  assign code = KEYMAP[{rowEnc(latRow), colIdx}];
  assign xfer = code_valid && code_ready;
  assign accept = !code_valid || code_ready;

  // The column stays frozen from detection until release is debounced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SCAN;
      scanCnt <= '0;
      dbCnt <= '0;
      colIdx <= '0;
      latRow <= 4'hF;
    end else begin
      case (state)
        SCAN:
          if (scanCnt != SCAN_LAST) scanCnt <= scanCnt + 1'b1;
          else if (!allHigh) begin
            latRow <= rowS;
            dbCnt <= '0;
            scanCnt <= '0;
            state <= PRESS_DB;
          end else begin
            scanCnt <= '0;
            colIdx <= colIdx + 2'd1;
          end
        PRESS_DB:
          if (rowS != latRow) begin
            state <= SCAN;
            scanCnt <= '0;
            colIdx <= colIdx + 2'd1;
          end else if (dbCnt == DB_LAST) state <= HELD;
          else dbCnt <= dbCnt + 1'b1;
        HELD:
          if (allHigh) begin
            dbCnt <= '0;
            state <= RELEASE_DB;
          end
        RELEASE_DB:
          if (!allHigh) state <= HELD;
          else if (dbCnt == DB_LAST) begin
            state <= SCAN;
            scanCnt <= '0;
            colIdx <= colIdx + 2'd1;
          end else dbCnt <= dbCnt + 1'b1;
        default: state <= SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_data <= '0;
      code_valid <= 1'b0;
      digits <= '0;
      overflow <= 1'b0;
    end else begin
      if (emit && accept) begin
        code_data <= code;
        code_valid <= 1'b1;
        digits <= {digits[11:0], code};
      end else if (xfer) code_valid <= 1'b0;
      overflow <= (emit && !accept) || (overflow && !xfer);
    end
  end
endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: keypad model driving the encoder; expected codes come from
// the printed key legends and are checked by a scoreboard on every transfer.
module tb_keypad_encoder;
  localparam int SD = 4;
  localparam int DB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        code_ready = 1'b1;
  logic [3:0]  row_i, col_o, code_data;
  logic        code_valid, overflow;
  logic [15:0] digits;
  logic [15:0] pressed = '0;
  logic [15:0] expDigits = '0;

  typedef struct packed {logic [3:0] code; logic [15:0] dig;} exp_t;
  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;
  string keyChars = "123A456B789CE0FD";

  keypad_encoder #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk(clk), .rst_n(rst_n), .row_i(row_i), .col_o(col_o),
    .code_data(code_data), .code_valid(code_valid), .code_ready(code_ready),
    .digits(digits), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column; rows are pulled up otherwise.
  always_comb begin
    row_i = 4'hF;
    for (int r = 0; r < 4; r++) row_i[r] = ~|(pressed[r*4 +: 4] & ~col_o);
  end

  function automatic logic [3:0] hexOf(input int k);
    byte ch;
    ch = keyChars[k];
    return ch >= 8'd65 ? 4'(ch - 8'd55) : 4'(ch - 8'd48);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expectKey(input int k);
    expDigits = {expDigits[11:0], hexOf(k)};
    sb.push_back('{hexOf(k), expDigits});
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tap(input int k, input int hold, input int gap, input bit want);
    if (want) expectKey(k);
    pressed[k] = 1'b1;
    cycles(hold);
    pressed[k] = 1'b0;
    cycles(gap);
  endtask

  task automatic waitValid(input string name, input int lo, input int hi);
    int n;
    n = 0;
    while (!code_valid && n < hi) begin
      cycles(1);
      n++;
    end
    compared++;
    if (!code_valid || n < lo) begin
      mismatched++;
      $display("FAIL %s: valid after %0d cycles (valid=%0b), expected within %0d..%0d",
               name, n, code_valid, lo, hi);
    end
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_col"}, 32'(col_o), 32'(4'b1110));
    check({tag, "_valid"}, 32'(code_valid), 32'(1'b0));
    check({tag, "_digits"}, 32'(digits), 32'(16'h0000));
    check({tag, "_overflow"}, 32'(overflow), 32'(1'b0));
  endtask

  always @(negedge clk)
    if (rst_n && code_valid && code_ready) begin
      exp_t e;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_code: got %0h, expected none", code_data);
      end else begin
        e = sb.pop_front();
        check("code_data", 32'(code_data), 32'(e.code));
        check("digits", 32'(digits), 32'(e.dig));
      end
    end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cycles(2);
    checkReset("reset");
    rst_n = 1'b1;

    expectKey(6);
    pressed[6] = 1'b1;
    waitValid("press6_latency", 10, 27);
    for (int i = 0; i < 20; i++) begin
      cycles(5);
      check("col_frozen", 32'(col_o), 32'(4'b1011));
    end
    cycles(70);
    pressed[6] = 1'b0;
    cycles(25);
    check("digits_after_6", 32'(digits), 32'(16'h0006));

    #3 rst_n = 1'b0;
    #1 checkReset("reset_mid_scan");
    expDigits = '0;
    cycles(2);
    rst_n = 1'b1;

    pressed[7] = 1'b1;
    cycles(5);
    #3 rst_n = 1'b0;
    #1 checkReset("reset_mid_debounce");
    cycles(3);
    rst_n = 1'b1;
    expectKey(7);
    waitValid("rediscover_latency", 10, 27);
    cycles(40);
    pressed[7] = 1'b0;
    cycles(25);

    expectKey(13);
    for (int i = 0; i < 10; i++) begin
      pressed[13] = ~i[0];
      cycles(3);
    end
    pressed[13] = 1'b1;
    waitValid("bounce_latency", 10, 27);
    cycles(40);
    pressed[13] = 1'b0;
    cycles(25);

    for (int k = 0; k < 4; k++) tap(k, 40, 20, 1'b1);
    check("digits_seq", 32'(digits), 32'(16'h123A));

    code_ready = 1'b0;
    tap(5, 40, 20, 1'b1);
    tap(10, 40, 20, 1'b0);
    check("bp_valid", 32'(code_valid), 32'(1'b1));
    check("bp_data", 32'(code_data), 32'(4'h5));
    check("bp_overflow", 32'(overflow), 32'(1'b1));
    check("bp_digits", 32'(digits), 32'(expDigits));
    code_ready = 1'b1;
    cycles(1);
    code_ready = 1'b0;
    check("bp_valid_cleared", 32'(code_valid), 32'(1'b0));
    cycles(1);
    check("bp_overflow_cleared", 32'(overflow), 32'(1'b0));
    code_ready = 1'b1;

    expectKey(0);
    pressed[0] = 1'b1;
    pressed[8] = 1'b1;
    cycles(40);
    pressed[0] = 1'b0;
    cycles(30);
    pressed[8] = 1'b0;
    cycles(25);

    repeat (12) tap(int'($urandom_range(15)), int'($urandom_range(70, 40)),
                    int'($urandom_range(35, 20)), 1'b1);

    cycles(10);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("final_overflow", 32'(overflow), 32'(1'b0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/keypad_encoder.md
# keypad_encoder

Scans a 4x4 active-low hex keypad, debounces the pressed key, and encodes it to a 4-bit hex code. The code is delivered on a valid/ready handshake and shifted into a 16-bit digit register. The block is the input-side counterpart of the seven-segment decoder path: `digits` drives the decoder's 16-bit value input, so keyed digits appear on the display.

## Interface
Parameters:
- `SCAN_DIV`, 50000: clock cycles each column is driven (minimum 4).
- `DEBOUNCE_CNT`, 1000000: cycles a row pattern must stay stable for press or release (minimum 2).

Ports:
- `clk`, in, 1: single system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `row_i`, in, 4: keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col_o`, out, 4: column drive, active-low, exactly one bit low at all times.
- `code_data`, out, 4: hex code of the last accepted key.
- `code_valid`, out, 1: `code_data` holds an unconsumed code.
- `code_ready`, in, 1: consumer accepts the code.
- `digits`, out, 16: last four accepted codes; newest in [3:0].
- `overflow`, out, 1: sticky flag; a key was dropped because the previous code was still pending.

## Operation
- `row_i` passes through a 2-flop synchronizer that resets to 4'hF. All logic uses the synchronized value `row_s`.
- Column index `col_idx` (2 bits) drives `col_o = ~(4'b0001 << col_idx)`.
- Key map, by row r and column c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- When more than one row is low, the lowest-index low row wins.
- FSM states: SCAN, PRESS_DB, HELD, RELEASE_DB.
- SCAN:
  - `scan_cnt` counts 0..SCAN_DIV-1. At the terminal count, `col_idx` increments mod 4 and `scan_cnt` clears.
  - The sample point is `scan_cnt == SCAN_DIV-1`.
  - If `row_s != 4'hF` at the sample point: latch `row_s` and `col_idx`, freeze the column, clear `db_cnt`, go to PRESS_DB. The column does not advance.
- PRESS_DB:
  - `db_cnt` increments each cycle while `row_s` equals the latched pattern.
  - Any mismatch returns to SCAN, with `scan_cnt` cleared and the column advanced.
  - At `db_cnt == DEBOUNCE_CNT-1`, the key is emitted and the FSM goes to HELD.
- Emit:
  - If `code_valid` is 0, or `code_ready` is 1 in the same cycle: load `code_data`, set `code_valid`, and shift `digits <= {digits[11:0], code}`.
  - Otherwise: drop the code, set `overflow`, and leave `digits` unchanged.
- HELD: column stays frozen. `row_s == 4'hF` clears `db_cnt` and moves to RELEASE_DB.
- RELEASE_DB:
  - Any low row returns to HELD; no new code is emitted.
  - `DEBOUNCE_CNT` consecutive all-high cycles return to SCAN, with the column advanced. Auto-repeat does not exist.
- Handshake:
  - A transfer occurs on a cycle with `code_valid && code_ready`. It clears `code_valid` unless an emit happens in the same cycle; in that case valid stays high with the new data.
  - `code_data` is stable while valid is high and ready is low.
- `overflow` clears on the cycle after a transfer completes, unless a new drop occurs in that cycle.

## Timing
- Reset values: `col_o = 4'b1110`, `code_data = 0`, `code_valid = 0`, `digits = 16'h0000`, `overflow = 0`, state SCAN, all counters 0, synchronizer 4'hF.
- Pin-to-`row_s` latency is 2 cycles.
- Press accepted at sample cycle T:
  - PRESS_DB is occupied at T+1..T+DEBOUNCE_CNT.
  - `code_valid` and the new `digits` are visible at T+DEBOUNCE_CNT+1.
- Worst-case detection latency is 4·SCAN_DIV + 2 + DEBOUNCE_CNT + 1 cycles from a stable press.
- Reset asserted mid-debounce or mid-hold aborts everything, with no emit. After release of reset, a key still held is rediscovered through SCAN.
- `code_ready` may be held high permanently. Each emit then produces exactly one valid cycle.

## Structure
- Package `keypad_pkg`:
  - FSM state enum `kp_state_t`.
  - `KEYMAP` constant, 16 entries of 4 bits, indexed {row, col}.
  - Row priority encode function.
- Sub-module `sync2` is the 2-flop, 4-bit synchronizer. It is reused for other async board inputs.
- The top holds the FSM, the counters, the output register and the digit shift register.

## Test plan
All scenarios use `SCAN_DIV=4`, `DEBOUNCE_CNT=8`, with a keypad model that shorts row r to column c while key (r,c) is pressed.
- Reset: `rst_n` low mid-scan -> `col_o=4'b1110`, `code_valid=0`, `digits=0`, `overflow=0` immediately (asynchronous).
- Clean press of (r1,c2) held for 200 cycles -> a single `code_valid` with `code_data=4'h6` and `digits=16'h0006`. `col_o` stays `4'b1011` until release.
- Bounce: press (r3,c1) toggling every 3 cycles for 30 cycles, then stable -> exactly one code 4'h0, emitted 8 cycles after the first stable sample.
- Sequence 1, 2, 3, A with `code_ready=1` -> `digits=16'h123A` and 4 single-cycle valids.
- Backpressure: `code_ready=0`, press 5 then 9 -> `code_data` stays 4'h5, `overflow=1`, `digits=16'h0005`. Ready then pulsed high for one cycle -> `code_valid=0`, and `overflow=0` on the next cycle.
- Two keys in the same column, (r0,c0) and (r2,c0) -> code 4'h1 only. Release (r0) while (r2) is held -> no new code until full release.
